// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the output-RAM write arbiter.
// Holds the FSM state encoding and the round-robin winner search.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  localparam int DEFAULT_MEM_ACCESS_LATENCY = 2;
  localparam int MAX_REQ = 8;

  // First valid requester found scanning n slots upward from ptr, wrapping.
  function automatic logic [2:0] next_rr_winner(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         ptr,
    input int                 n = MAX_REQ
  );
    logic [2:0] w;
    logic       found;
    int         idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n && !found) begin
        idx = (int'(ptr) + i) % n;
        if (valid[idx]) begin
          w     = 3'(idx);
          found = 1'b1;
        end
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_wr_arbiter_rr_priority_select.sv
// Winner select plus registered round-robin pointer.
// ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead.
module rr_priority_select
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               adv_i,
  output logic [IW-1:0]      win_o,
  output logic               any_o
);

  logic [MAX_REQ-1:0] v8;

  always_comb begin
    v8 = '0;
    v8[NUM_REQ-1:0] = valid_i;
  end

  assign any_o = |valid_i;

`ifdef ARB_FIXED_PRIO_EN
  assign win_o = IW'(next_rr_winner(v8, 3'd0, NUM_REQ));
`else
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  assign win_o = IW'(next_rr_winner(v8, 3'(ptr_q), NUM_REQ));

  // Pointer names the requester with top priority next round.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      if (win_o == IW'(NUM_REQ - 1)) ptr_d = '0;
      else ptr_d = win_o + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/mem_wr_arbiter.sv
// Round-robin arbiter sharing the output-RAM write port.
// Define ARB_FIXED_PRIO_EN for fixed priority; MEM_PORT_WIDTH from header_ws.vh.
`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 64
`endif

module mem_wr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ            = 2,
  parameter  int ADDR_WIDTH         = 32,
  parameter  int DATA_WIDTH         = `MEM_PORT_WIDTH,
  parameter  int MEM_ACCESS_LATENCY = DEFAULT_MEM_ACCESS_LATENCY,
  localparam int IW                 = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_data,
  output logic                          mem_wr_en,
  output logic [IW-1:0]                 grant_idx,
  output logic                          busy
);

  localparam int DLY_W =
    (MEM_ACCESS_LATENCY > 2) ? $clog2(MEM_ACCESS_LATENCY) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD =
    DLY_W'(MEM_ACCESS_LATENCY - 2);

  state_e                 state_q, state_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [NUM_REQ-1:0]     rdy_q, rdy_d;
  logic                   wr_q, wr_d;
  logic                   adv;
  logic [IW-1:0]          win;
  logic                   any;

  rr_priority_select #(
    .NUM_REQ(NUM_REQ)
  ) u_sel (
    .clk    (clk),
    .rst    (rst),
    .valid_i(req_valid),
    .adv_i  (adv),
    .win_o  (win),
    .any_o  (any)
  );

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    addr_d  = addr_q;
    data_d  = data_q;
    gidx_d  = gidx_q;
    rdy_d   = '0;
    wr_d    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!stall && any) begin
          adv     = 1'b1;
          addr_d  = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
          data_d  = req_data[win*DATA_WIDTH +: DATA_WIDTH];
          gidx_d  = win;
          rdy_d   = NUM_REQ'(1) << win;
          wr_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (MEM_ACCESS_LATENCY == 1) begin
          state_d = IDLE;
        end else begin
          dly_d   = DLY_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Counts down regardless of stall.
        if (dly_q == '0) state_d = IDLE;
        else dly_d = dly_q - DLY_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dly_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      gidx_q  <= '0;
      rdy_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gidx_q  <= gidx_d;
      rdy_q   <= rdy_d;
      wr_q    <= wr_d;
    end
  end

  assign req_ready = rdy_q;
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign mem_wr_en = wr_q;
  assign grant_idx = gidx_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Scoreboard bench for mem_wr_arbiter against a cooldown/round-robin model.
// Directed scenarios followed by a randomized requester phase.
module tb_mem_wr_arbiter;

  localparam int N   = 3;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int IW  = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wr_en;
  logic [IW-1:0] grant_idx;
  logic          busy;

  mem_wr_arbiter #(
    .NUM_REQ           (N),
    .ADDR_WIDTH        (AW),
    .DATA_WIDTH        (DW),
    .MEM_ACCESS_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wr_en(mem_wr_en),
    .grant_idx(grant_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    int            idx;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           last_g = N - 1;
  int           cool = 0;
  bit           exp_busy = 1'b0;
  int           n_wr = 0;
  int           n_rdy = 0;
  bit           auto_en = 1'b0;
  int           prob = 0;
  logic [N-1:0] active = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Model: a grant starts a cooldown of LAT skipped edges.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      last_g = N - 1;
      cool   = 0;
    end else if (cool == 0 && !stall && req_valid != '0) begin
      int   s;
      int   w;
      exp_t e;
`ifdef ARB_FIXED_PRIO_EN
      s = 0;
`else
      s = (last_g + 1) % N;
`endif
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(s + k) % N]) w = (s + k) % N;
      e.cyc = cyc;
      e.idx = w;
      e.a   = req_addr[w*AW +: AW];
      e.d   = req_data[w*DW +: DW];
      q.push_back(e);
      last_g = w;
      cool   = LAT;
    end else if (cool > 0) begin
      cool--;
    end
    exp_busy = (cool > 0);
  end

  // Monitor
  always @(negedge clk) begin
    exp_t         e;
    logic [N-1:0] r;
    chk("busy", 64'(busy), 64'(exp_busy));
    if (req_ready != '0) n_rdy++;
    if (mem_wr_en) begin
      n_wr++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write got addr=%0h exp=none cyc=%0d",
                 mem_addr, cyc);
      end else begin
        e = q.pop_front();
        r = '0;
        r[e.idx] = 1'b1;
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        chk("grant_idx", 64'(grant_idx), 64'(e.idx));
        chk("mem_addr", 64'(mem_addr), 64'(e.a));
        chk("mem_data", 64'(mem_data), 64'(e.d));
        chk("req_ready", 64'(req_ready), 64'(r));
      end
    end else begin
      chk("ready_idle", 64'(req_ready), 64'(0));
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write got=none exp=req%0d cyc=%0d",
                 e.idx, e.cyc);
      end
    end
  end

  task automatic new_req(int i);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = AW'($urandom);
    req_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        if (auto_en && active[i] && $urandom_range(99) < prob)
          new_req(i);
        else
          req_valid[i] = 1'b0;
      end else if (!req_valid[i]) begin
        if (auto_en && active[i] && $urandom_range(99) < prob)
          new_req(i);
      end else if (auto_en && prob < 100 && $urandom_range(99) < 3) begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_wr(string nm);
    int t;
    t = 0;
    do begin
      step();
      t++;
    end while (!mem_wr_en && t < 30);
    if (!mem_wr_en) begin
      checks++;
      errors++;
      $display("FAIL %s got=no_strobe exp=strobe", nm);
    end
  endtask

  task automatic chk_reset_outs(string nm);
    chk({nm, "_wr_en"}, 64'(mem_wr_en), 64'(0));
    chk({nm, "_addr"}, 64'(mem_addr), 64'(0));
    chk({nm, "_data"}, 64'(mem_data), 64'(0));
    chk({nm, "_ready"}, 64'(req_ready), 64'(0));
    chk({nm, "_gidx"}, 64'(grant_idx), 64'(0));
    chk({nm, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    stall     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) step();
    chk_reset_outs("reset");
    rst = 1'b0;
    step();

    // Single write
    req_valid[0] = 1'b1;
    req_addr[0 +: AW] = 16'h0100;
    req_data[0 +: DW] = 16'hBEEF;
    wait_wr("single");
    chk("single_addr", 64'(mem_addr), 64'(16'h0100));
    chk("single_data", 64'(mem_data), 64'(16'hBEEF));
    repeat (8) step();
    chk("single_hold_addr", 64'(mem_addr), 64'(16'h0100));

    // Contention between requesters 0 and 1
    auto_en = 1'b1;
    prob    = 100;
    active  = 3'b011;
    repeat (14) step();
    active = '0;
    repeat (12) step();

    // Stall holds off arbitration
    auto_en = 1'b0;
    stall   = 1'b1;
    new_req(0);
    new_req(1);
    repeat (10) step();
    chk("stall_busy", 64'(busy), 64'(0));
    chk("stall_no_wr", 64'(n_wr), 64'(n_rdy));
    stall = 1'b0;
    wait_wr("stall_release");
    repeat (12) step();

    // Reset in the cycle after ISSUE
    auto_en = 1'b1;
    active  = 3'b011;
    wait_wr("pre_reset");
    step();
    rst = 1'b1;
    step();
    chk_reset_outs("midrst");
    rst = 1'b0;
    wait_wr("post_reset");
    chk("rr_restart", 64'(grant_idx), 64'(0));
    active = '0;
    repeat (12) step();

    // Requester 1 pulses valid only while busy
    auto_en = 1'b0;
    new_req(0);
    wait_wr("withdraw_a");
    new_req(1);
    step();
    req_valid[1] = 1'b0;
    repeat (8) step();
    chk("withdraw_cnt", 64'(n_wr), 64'(n_rdy));

    // Random traffic
    auto_en = 1'b1;
    prob    = 60;
    active  = 3'b111;
    repeat (400) begin
      step();
      stall = ($urandom_range(99) < 15);
    end
    stall  = 1'b0;
    active = '0;
    repeat (30) step();

    chk("queue_empty", 64'(q.size()), 64'(0));
    chk("wr_vs_ready", 64'(n_wr), 64'(n_rdy));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
